// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage: default widths, FSM state encoding and
// small decode helpers used by the stage and its timeout counter.
package mem_access_stage_pkg;

    // Default data/address width of the pipeline.
    localparam int unsigned DSIZE_DEF   = 16;
    // Default register-file index width.
    localparam int unsigned RSIZE_DEF   = 4;
    // Default number of BUSY cycles allowed before an access is aborted.
    localparam int unsigned TIMEOUT_DEF = 15;

    // MEM-stage FSM: idle/accepting, or waiting on data memory.
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_BUSY = 1'b1
    } mem_state_e;

    // Any load or store needs the data-memory handshake.
    function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

    // A load wins when both flags are set, so only a pure store writes memory.
    function automatic logic is_store(input logic mem_read, input logic mem_write);
        return mem_write & ~mem_read;
    endfunction

endpackage

// File: rtl/mem_access_stage_dmem_timeout_ctr.sv
// Timeout counter for outstanding data-memory accesses.
// Only instantiated when DMEM_TIMEOUT_EN is defined.
module dmem_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Count BUSY cycles that end without an ack; clear when a new access starts.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CW'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expired in the cycle whose missing ack would take the count to TIMEOUT,
    // so the abort lands on the edge after exactly TIMEOUT BUSY cycles.
    assign o_expired = (r_count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage of the 16-bit pipeline. Non-memory results pass to writeback with
// one cycle of latency; loads/stores run a req/ack handshake with data memory
// while stalling upstream. Optional access timeout: define DMEM_TIMEOUT_EN.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int unsigned DSIZE   = DSIZE_DEF,
    parameter int unsigned RSIZE   = RSIZE_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    // EX-stage result
    input  logic             i_in_valid,
    input  logic [DSIZE-1:0] i_alu_out,
    input  logic [DSIZE-1:0] i_st_data,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic             i_reg_write,
    input  logic [RSIZE-1:0] i_rd,
    output logic             o_stall,
    // Data memory
    output logic             o_dmem_req,
    output logic             o_dmem_we,
    output logic [DSIZE-1:0] o_dmem_addr,
    output logic [DSIZE-1:0] o_dmem_wdata,
    input  logic             i_dmem_ack,
    input  logic [DSIZE-1:0] i_dmem_rdata,
    // Writeback
    output logic             o_wb_valid,
    output logic             o_wb_we,
    output logic [RSIZE-1:0] o_wb_rd,
    output logic [DSIZE-1:0] o_wb_data,
    output logic             o_err
);

    mem_state_e       r_state;
    logic             r_dmem_req;
    logic             r_dmem_we;
    logic [DSIZE-1:0] r_dmem_addr;
    logic [DSIZE-1:0] r_dmem_wdata;
    logic [RSIZE-1:0] r_rd;
    logic             r_reg_write;
    logic             r_wb_valid;
    logic             r_wb_we;
    logic [RSIZE-1:0] r_wb_rd;
    logic [DSIZE-1:0] r_wb_data;

    logic w_busy;
    logic w_mem_op;
    logic w_start;
    logic w_abort;

    assign w_busy   = (r_state == MEM_BUSY);
    assign w_mem_op = is_mem_op(i_mem_read, i_mem_write);
    // A memory access is accepted only from IDLE; BUSY ignores in_valid.
    assign w_start  = ~w_busy & i_in_valid & w_mem_op;

`ifdef DMEM_TIMEOUT_EN
    logic w_expired;
    logic r_err;

    dmem_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_start),
        .i_inc     (w_busy & ~i_dmem_ack),
        .o_expired (w_expired)
    );

    // An ack in the expiry cycle wins, so the abort requires no ack.
    assign w_abort = w_busy & ~i_dmem_ack & w_expired;

    // One-cycle error pulse accompanying the aborted writeback.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_abort;
        end
    end

    assign o_err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^TIMEOUT;
    assign w_abort          = 1'b0;
    assign o_err            = 1'b0;
`endif

    // Stage FSM with registered memory-request and writeback outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= MEM_IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_wb_we      <= 1'b0;
            r_wb_rd      <= '0;
            r_wb_data    <= '0;
        end else begin
            // Writeback is a single-cycle pulse unless set below.
            r_wb_valid <= 1'b0;
            case (r_state)
                MEM_IDLE: begin
                    if (i_in_valid) begin
                        if (w_mem_op) begin
                            // Latch the whole access; it is held until ack.
                            r_dmem_req   <= 1'b1;
                            r_dmem_we    <= is_store(i_mem_read, i_mem_write);
                            r_dmem_addr  <= i_alu_out;
                            r_dmem_wdata <= i_st_data;
                            r_rd         <= i_rd;
                            r_reg_write  <= i_reg_write;
                            r_state      <= MEM_BUSY;
                        end else begin
                            r_wb_valid <= 1'b1;
                            r_wb_we    <= i_reg_write;
                            r_wb_rd    <= i_rd;
                            r_wb_data  <= i_alu_out;
                        end
                    end
                end
                MEM_BUSY: begin
                    if (i_dmem_ack) begin
                        r_dmem_req <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        if (r_dmem_we) begin
                            // Stores never write the register file.
                            r_wb_we   <= 1'b0;
                            r_wb_data <= '0;
                        end else begin
                            r_wb_we   <= r_reg_write;
                            r_wb_data <= i_dmem_rdata;
                        end
                        r_state <= MEM_IDLE;
                    end else if (w_abort) begin
                        r_dmem_req <= 1'b0;
                        r_wb_valid <= 1'b1;
                        r_wb_we    <= 1'b0;
                        r_wb_rd    <= r_rd;
                        r_wb_data  <= '0;
                        r_state    <= MEM_IDLE;
                    end
                end
                default: begin
                    r_state <= MEM_IDLE;
                end
            endcase
        end
    end

    // Stall covers every BUSY cycle, including the ack cycle.
    assign o_stall      = w_busy;
    assign o_dmem_req   = r_dmem_req;
    assign o_dmem_we    = r_dmem_we;
    assign o_dmem_addr  = r_dmem_addr;
    assign o_dmem_wdata = r_dmem_wdata;
    assign o_wb_valid   = r_wb_valid;
    assign o_wb_we      = r_wb_we;
    assign o_wb_rd      = r_wb_rd;
    assign o_wb_data    = r_wb_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
// Define DMEM_TIMEOUT_EN to exercise the timeout path (TIMEOUT = 4).
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] alu_out = '0;
    logic [15:0] st_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        reg_write = 1'b0;
    logic [3:0]  rd = '0;
    logic        ack = 1'b0;
    logic [15:0] rdata = '0;

    logic        stall, dmem_req, dmem_we, wb_valid, wb_we, err;
    logic [15:0] dmem_addr, dmem_wdata, wb_data;
    logic [3:0]  wb_rd;

    int tests = 0;
    int fails = 0;

    // Transaction model state
    bit          m_busy = 0;
    bit          m_accepted = 0;
    int          m_cycles = 0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;
    bit          m_is_store = 0;
    logic [3:0]  m_rd = '0;
    bit          m_rw = 0;

    // Expected outputs after the most recent edge
    bit          e_stall = 0, e_req = 0, e_wbv = 0, e_wbwe = 0, e_err = 0;
    logic [3:0]  e_wbrd = '0;
    logic [15:0] e_wbdata = '0;

    bit cmp_en = 1'b1;

    always #5 clk = ~clk;

    mem_access_stage #(
        .DSIZE   (16),
        .RSIZE   (4),
        .TIMEOUT (TO)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_in_valid   (in_valid),
        .i_alu_out    (alu_out),
        .i_st_data    (st_data),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_reg_write  (reg_write),
        .i_rd         (rd),
        .o_stall      (stall),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_dmem_addr  (dmem_addr),
        .o_dmem_wdata (dmem_wdata),
        .i_dmem_ack   (ack),
        .i_dmem_rdata (rdata),
        .o_wb_valid   (wb_valid),
        .o_wb_we      (wb_we),
        .o_wb_rd      (wb_rd),
        .o_wb_data    (wb_data),
        .o_err        (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs presented for that edge.
    task automatic model_step();
        m_accepted = 0;
        e_wbv      = 0;
        e_err      = 0;
        if (rst) begin
            m_busy = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_accepted = 1;
                if (mem_read || mem_write) begin
                    m_busy     = 1;
                    m_cycles   = 0;
                    m_addr     = alu_out;
                    m_wdata    = st_data;
                    m_is_store = !mem_read;
                    m_rd       = rd;
                    m_rw       = reg_write;
                end else begin
                    e_wbv    = 1;
                    e_wbrd   = rd;
                    e_wbwe   = reg_write;
                    e_wbdata = alu_out;
                end
            end
        end else begin
            m_cycles++;
            if (ack) begin
                m_busy   = 0;
                e_wbv    = 1;
                e_wbrd   = m_rd;
                e_wbwe   = m_is_store ? 1'b0 : m_rw;
                e_wbdata = m_is_store ? 16'h0 : rdata;
            end
`ifdef DMEM_TIMEOUT_EN
            else if (m_cycles == TO) begin
                m_busy   = 0;
                e_wbv    = 1;
                e_wbwe   = 0;
                e_wbdata = 16'h0;
                e_err    = 1;
            end
`endif
        end
        e_stall = m_busy;
        e_req   = m_busy;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input logic [15:0] a, input logic [15:0] s,
                          input bit mr, input bit mw, input bit rw, input logic [3:0] r);
        in_valid  = v;
        alu_out   = a;
        st_data   = s;
        mem_read  = mr;
        mem_write = mw;
        reg_write = rw;
        rd        = r;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("stall", stall, e_stall);
            check("dmem_req", dmem_req, e_req);
            check("wb_valid", wb_valid, e_wbv);
            check("err", err, e_err);
            if (e_req) begin
                check("dmem_addr", dmem_addr, m_addr);
                check("dmem_we", dmem_we, m_is_store);
                check("dmem_wdata", dmem_wdata, m_wdata);
            end
            if (e_wbv) begin
                check("wb_we", wb_we, e_wbwe);
                check("wb_data", wb_data, e_wbdata);
                if (!e_err) check("wb_rd", wb_rd, e_wbrd);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit new_instr;
        int sel;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_stall", stall, 0);
        check("rst_req", dmem_req, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_err", err, 0);
        check("rst_wb_data", wb_data, 16'h0);
        check("rst_dmem_addr", dmem_addr, 16'h0);

        // Back-to-back non-memory results
        set_in(1, 16'h1234, 16'h0, 0, 0, 1, 4'd3);
        tick();
        check("alu1_valid", wb_valid, 1);
        check("alu1_data", wb_data, 16'h1234);
        check("alu1_rd", wb_rd, 3);
        check("alu1_we", wb_we, 1);
        check("alu1_stall", stall, 0);
        set_in(1, 16'hFFFF, 16'h0, 0, 0, 1, 4'd4);
        tick();
        check("alu2_valid", wb_valid, 1);
        check("alu2_data", wb_data, 16'hFFFF);
        check("alu2_rd", wb_rd, 4);
        check("alu2_stall", stall, 0);
        in_valid = 0;
        tick();
        check("alu_idle_valid", wb_valid, 0);

        // Load acked in the third BUSY cycle
        set_in(1, 16'h0040, 16'h0, 1, 0, 1, 4'd5);
        tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            check("ld_stall", stall, 1);
            check("ld_req", dmem_req, 1);
            check("ld_addr", dmem_addr, 16'h0040);
            check("ld_we", dmem_we, 0);
            if (i < 2) tick();
        end
        ack   = 1;
        rdata = 16'hBEEF;
        tick();
        ack = 0;
        check("ld_wb_valid", wb_valid, 1);
        check("ld_wb_data", wb_data, 16'hBEEF);
        check("ld_wb_rd", wb_rd, 5);
        check("ld_wb_we", wb_we, 1);
        check("ld_done_stall", stall, 0);
        check("ld_done_req", dmem_req, 0);

        // Store acked immediately, ALU op held under stall
        set_in(1, 16'h0010, 16'hA5A5, 0, 1, 0, 4'd6);
        tick();
        check("st_req", dmem_req, 1);
        check("st_we", dmem_we, 1);
        check("st_wdata", dmem_wdata, 16'hA5A5);
        check("st_addr", dmem_addr, 16'h0010);
        set_in(1, 16'h0077, 16'h0, 0, 0, 1, 4'd7);
        ack = 1;
        tick();
        ack = 0;
        check("st_wb_valid", wb_valid, 1);
        check("st_wb_we", wb_we, 0);
        check("st_wb_data", wb_data, 16'h0);
        check("st_done_stall", stall, 0);
        tick();
        in_valid = 0;
        check("add_wb_valid", wb_valid, 1);
        check("add_wb_data", wb_data, 16'h0077);
        check("add_wb_rd", wb_rd, 7);

        // Both read and write set behaves as a load
        set_in(1, 16'h0020, 16'h5555, 1, 1, 1, 4'd2);
        tick();
        in_valid = 0;
        check("both_req", dmem_req, 1);
        check("both_we", dmem_we, 0);
        ack   = 1;
        rdata = 16'h1111;
        tick();
        ack = 0;
        check("both_wb_we", wb_we, 1);
        check("both_wb_data", wb_data, 16'h1111);

        // Reset in the middle of an access, then a stray ack
        set_in(1, 16'h0030, 16'h0, 1, 0, 1, 4'd8);
        tick();
        in_valid = 0;
        check("rstmid_req_before", dmem_req, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rstmid_req", dmem_req, 0);
        check("rstmid_stall", stall, 0);
        check("rstmid_wb_valid", wb_valid, 0);
        ack   = 1;
        rdata = 16'h2222;
        tick();
        ack = 0;
        check("stray_wb_valid", wb_valid, 0);
        check("stray_stall", stall, 0);
        tick();

        // Unacknowledged load
        set_in(1, 16'h0050, 16'h0, 1, 0, 1, 4'd9);
        tick();
        in_valid = 0;
`ifdef DMEM_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_req_held", dmem_req, 1);
        end
        tick();
        check("to_req", dmem_req, 0);
        check("to_err", err, 1);
        check("to_wb_valid", wb_valid, 1);
        check("to_wb_we", wb_we, 0);
        check("to_wb_data", wb_data, 16'h0);
        tick();
        check("to_err_pulse", err, 0);
        // Ack in the final allowed cycle completes normally
        set_in(1, 16'h0060, 16'h0, 1, 0, 1, 4'd10);
        tick();
        in_valid = 0;
        for (int i = 0; i < 3; i++) tick();
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("wait_req_held", dmem_req, 1);
        end
`endif
        ack   = 1;
        rdata = 16'h3333;
        tick();
        ack = 0;
        check("late_ack_err", err, 0);
        check("late_ack_wb_valid", wb_valid, 1);
        check("late_ack_wb_we", wb_we, 1);
        check("late_ack_wb_data", wb_data, 16'h3333);

        // Randomized traffic
        new_instr = 1;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (new_instr) begin
                sel       = int'($urandom_range(0, 9));
                in_valid  = ($urandom_range(0, 3) != 0);
                mem_read  = (sel < 3) || (sel == 4);
                mem_write = (sel == 3) || (sel == 4) || (sel == 5);
                reg_write = 1'($urandom);
                alu_out   = 16'($urandom);
                st_data   = 16'($urandom);
                rd        = 4'($urandom);
            end
            ack   = m_busy ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) == 0);
            rdata = 16'($urandom);
            tick();
            new_instr = m_accepted || !m_busy;
        end

        rst      = 0;
        in_valid = 0;
        ack      = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 16-bit pipeline; sits directly downstream of the EX-stage ALU and consumes its registered result.
- Non-memory instructions: registers the ALU result through to writeback.
- Loads/stores: uses the ALU result as the data-memory address and runs a req/ack handshake with variable-latency data memory.
- Asserts stall upstream while a memory access is outstanding.

Parameters:
- DSIZE, 16, data and address width; matches `DSIZE.
- RSIZE, 4, register-file index width.
- TIMEOUT, 15, max BUSY cycles before abort; used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  EX result valid this cycle.
- alu_out  in  DSIZE  ALU result; memory address for loads/stores.
- st_data  in  DSIZE  store data (rt value).
- mem_read  in  1  instruction is a load.
- mem_write  in  1  instruction is a store.
- reg_write  in  1  instruction writes the register file.
- rd  in  RSIZE  destination register.
- stall  out  1  upstream must hold all inputs stable while high.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  DSIZE  memory address.
- dmem_wdata  out  DSIZE  write data.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  DSIZE  read data; valid with dmem_ack.
- wb_valid  out  1  writeback bundle valid, one-cycle pulse.
- wb_we  out  1  register-file write enable.
- wb_rd  out  RSIZE  writeback destination.
- wb_data  out  DSIZE  writeback value.
- err  out  1  access aborted (DMEM_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- rst mid-access: dmem_req drops on the next edge; the in-flight instruction is discarded.
- States: IDLE, BUSY.
- stall = (state == BUSY), including the ack cycle.
  - Every memory access costs one bubble; completion and a new accept never share an edge.
- IDLE, in_valid, no memory op:
  - Next edge: wb_valid=1, wb_data=alu_out, wb_rd=rd, wb_we=reg_write.
  - Latency 1 cycle; back-to-back throughput 1 per cycle.
- IDLE, in_valid, mem_read or mem_write:
  - Next edge: latch dmem_addr=alu_out, dmem_wdata=st_data, dmem_we=mem_write & ~mem_read, and rd/reg_write.
  - Set dmem_req=1, wb_valid=0, go BUSY.
  - mem_read and mem_write both set: treated as a load.
- BUSY:
  - dmem_req and all dmem_* outputs are held stable until ack.
  - On dmem_ack, next edge: dmem_req=0, wb_valid=1, wb_rd=latched rd.
  - Load completion: wb_data=dmem_rdata, wb_we=latched reg_write.
  - Store completion: wb_we=0, wb_data=0.
  - Return to IDLE.
- Minimum load latency: accept edge → req; ack in the first BUSY cycle → wb_valid on the following edge (2 cycles).
- dmem_ack while IDLE: ignored.
- in_valid while BUSY: ignored; upstream is stalled and holds its inputs.
- wb_valid is low in every cycle not listed above.
- Address arithmetic: none; alu_out is used as-is, with no alignment check.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT+1) clears on BUSY entry and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT without ack, next edge: dmem_req=0, state IDLE, wb_valid=1, wb_we=0, wb_data=0, err=1 for one cycle.
  - Ack in the same cycle the count reaches TIMEOUT: the ack wins (normal completion, err=0).
- Without the macro: BUSY waits indefinitely, err is constant 0, and TIMEOUT is unused.

Decomposition:
- Shared definitions header (alongside `DSIZE): `RSIZE and the state encodings `MEM_IDLE / `MEM_BUSY.
- One optional sub-module: dmem_timeout_ctr (load/clear, increment, expired output), instantiated only under DMEM_TIMEOUT_EN.

Test Plan:
- Reset: assert rst during BUSY with dmem_req=1.
  - → next edge: dmem_req=0, stall=0, wb_valid=0.
  - → later stray ack is ignored.
- Non-memory stream: alu_out=0x1234,rd=3,reg_write=1, then 0xFFFF,rd=4, consecutive cycles.
  - → wb_valid on two consecutive edges with matching data/rd; stall never high.
- Load: alu_out=0x0040, mem_read=1, rd=5; ack with rdata=0xBEEF after 3 BUSY cycles.
  - → dmem_addr=0x0040, we=0 held stable throughout; stall high for 3 cycles.
  - → wb_data=0xBEEF, wb_rd=5, wb_we=1.
- Store then add: store 0xA5A5 to 0x0010, ack on first BUSY cycle, ALU op presented and held under stall.
  - → dmem_we=1, wdata=0xA5A5; store completes with wb_we=0.
  - → ALU result written back one edge later.
- Both mem_read and mem_write set → access issues as a read (dmem_we=0).
- DMEM_TIMEOUT_EN with TIMEOUT=4 and no ack.
  - → req drops after 4 BUSY cycles; err=1, wb_valid=1, wb_we=0.
  - Repeat with ack in the 4th cycle → normal completion, err=0.
